mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline: consumes EX/MEM register outputs, runs loads/stores on a

---
 rtl/mem_access_stage_if.sv | 22 ++
 rtl/mem_access_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// The stage owns the request side; the memory returns read data with a one-cycle ack.
interface mem_access_stage_if;
    localparam int unsigned XLEN = 32;

    logic            Dm_Req;
    logic            Dm_We;
    logic [XLEN-1:0] Dm_Addr;
    logic [XLEN-1:0] Dm_Wdata;
    logic [XLEN-1:0] Dm_Rdata;
    logic            Dm_Ack;

    modport master (
        output Dm_Req, Dm_We, Dm_Addr, Dm_Wdata,
        input  Dm_Rdata, Dm_Ack
    );

    modport slave (
        input  Dm_Req, Dm_We, Dm_Addr, Dm_Wdata,
        output Dm_Rdata, Dm_Ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores over a variable-latency req/ack bus with timeout,
// upstream stall while an access is in flight, branch/jump redirect and MEM/WB register.
module mem_access_stage #(
    parameter  int unsigned MAX_WAIT = 255,
    localparam int unsigned XLEN     = 32,
    localparam int unsigned REGW     = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              M_Valid,
    input  logic              M_MemRead,
    input  logic              M_MemWrite,
    input  logic              M_RegWrite,
    input  logic              M_MemtoReg,
    input  logic              M_Branch,
    input  logic              M_Jump,
    input  logic              M_Zero,
    input  logic              M_Overflow,
    input  logic [XLEN-1:0]   M_Btarg,
    input  logic [XLEN-1:0]   M_Jtarg,
    input  logic [XLEN-1:0]   M_ALUout,
    input  logic [XLEN-1:0]   M_busB,
    input  logic [REGW-1:0]   M_Rw,
    mem_access_stage_if.master dm,
    output logic              Mem_Stall,
    output logic [1:0]        PC_Sel,
    output logic [XLEN-1:0]   PC_Targ,
    output logic              W_Valid,
    output logic              W_RegWrite,
    output logic [REGW-1:0]   W_Rw,
    output logic [XLEN-1:0]   W_busW,
    output logic [1:0]        W_Exc
);
    localparam int unsigned CNTW = 8;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_MIS  = 2'b10;
    localparam logic [1:0] EXC_BUS  = 2'b11;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_JMP  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [CNTW-1:0]   wait_cnt;
    logic [REGW-1:0]   lat_rw;
    logic              lat_regwrite;
    logic              lat_memtoreg;

    logic              is_mem;
    logic              misaligned;
    logic              mem_op;
    logic [1:0]        slot_exc;
    logic              timeout;
    logic              access_end;

    // Classify the EX/MEM slot; overflow outranks misalignment and both block the bus.
    always_comb begin
        is_mem     = M_MemRead | M_MemWrite;
        misaligned = (M_ALUout[1:0] != 2'b00);
        mem_op     = M_Valid & is_mem & ~M_Overflow & ~misaligned;
        slot_exc   = EXC_NONE;
        if (M_Valid && M_Overflow)
            slot_exc = EXC_OVF;
        else if (M_Valid && is_mem && misaligned)
            slot_exc = EXC_MIS;
    end

    // An ack on the final WAIT cycle wins over the timeout.
    always_comb begin
        timeout    = (state == S_WAIT) && !dm.Dm_Ack && (wait_cnt == CNTW'(MAX_WAIT - 1));
        access_end = ((state == S_REQ) || (state == S_WAIT)) && (dm.Dm_Ack || timeout);
    end

    assign Mem_Stall = ((state == S_IDLE) && mem_op) || (state == S_REQ) || (state == S_WAIT);

    // Redirect only once the slot is actually leaving the stage.
    always_comb begin
        PC_Sel  = SEL_SEQ;
        PC_Targ = '0;
        if (M_Valid && !Mem_Stall) begin
            if (M_Jump) begin
                PC_Sel  = SEL_JMP;
                PC_Targ = M_Jtarg;
            end else if (M_Branch && M_Zero) begin
                PC_Sel  = SEL_BR;
                PC_Targ = M_Btarg;
            end
        end
    end

    always_ff @(negedge Clk) begin
        if (!Rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            dm.Dm_Req    <= 1'b0;
            dm.Dm_We     <= 1'b0;
            dm.Dm_Addr   <= '0;
            dm.Dm_Wdata  <= '0;
            lat_rw       <= '0;
            lat_regwrite <= 1'b0;
            lat_memtoreg <= 1'b0;
            W_Valid      <= 1'b0;
            W_RegWrite   <= 1'b0;
            W_Rw         <= '0;
            W_busW       <= '0;
            W_Exc        <= EXC_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        state        <= S_REQ;
                        wait_cnt     <= '0;
                        dm.Dm_Req    <= 1'b1;
                        dm.Dm_We     <= M_MemWrite;
                        dm.Dm_Addr   <= {M_ALUout[XLEN-1:2], 2'b00};
                        dm.Dm_Wdata  <= M_busB;
                        lat_rw       <= M_Rw;
                        lat_regwrite <= M_RegWrite & ~M_MemWrite;
                        lat_memtoreg <= M_MemtoReg;
                        W_Valid      <= 1'b0;
                        W_RegWrite   <= 1'b0;
                        W_Rw         <= '0;
                        W_busW       <= '0;
                        W_Exc        <= EXC_NONE;
                    end else begin
                        W_Valid    <= M_Valid;
                        W_RegWrite <= M_Valid & M_RegWrite & ~M_MemWrite & (slot_exc == EXC_NONE);
                        W_Rw       <= M_Rw;
                        W_busW     <= M_ALUout;
                        W_Exc      <= slot_exc;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (access_end) begin
                        state      <= S_DONE;
                        dm.Dm_Req  <= 1'b0;
                        W_Valid    <= 1'b1;
                        W_RegWrite <= lat_regwrite & dm.Dm_Ack;
                        W_Rw       <= lat_rw;
                        W_busW     <= lat_memtoreg ? (dm.Dm_Ack ? dm.Dm_Rdata : '0) : dm.Dm_Addr;
                        W_Exc      <= dm.Dm_Ack ? EXC_NONE : EXC_BUS;
                    end else begin
                        state    <= S_WAIT;
                        wait_cnt <= (state == S_REQ) ? '0 : wait_cnt + CNTW'(1);
                    end
                end
                S_DONE: begin
                    // Result was presented this cycle; the slot still holds the finished access.
                    state      <= S_IDLE;
                    W_Valid    <= 1'b0;
                    W_RegWrite <= 1'b0;
                    W_Rw       <= '0;
                    W_busW     <= '0;
                    W_Exc      <= EXC_NONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a transaction-level model predicts stall length,
// bus activity, redirects and the MEM/WB result of every instruction.
module tb_mem_access_stage;
    localparam int unsigned TB_MAX_WAIT = 4;

    typedef struct packed {
        logic        valid, rd, wr, regwrite, memtoreg, branch, jump, zero, ovf;
        logic [31:0] btarg, jtarg, alu, busb;
        logic [4:0]  rw;
    } instr_t;

    typedef struct packed {
        logic        valid, regwrite;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic [1:0]  exc;
    } wexp_t;

    logic        Clk, Rst_n;
    logic        M_Valid, M_MemRead, M_MemWrite, M_RegWrite, M_MemtoReg;
    logic        M_Branch, M_Jump, M_Zero, M_Overflow;
    logic [31:0] M_Btarg, M_Jtarg, M_ALUout, M_busB;
    logic [4:0]  M_Rw;
    logic        Mem_Stall;
    logic [1:0]  PC_Sel;
    logic [31:0] PC_Targ;
    logic        W_Valid, W_RegWrite;
    logic [4:0]  W_Rw;
    logic [31:0] W_busW;
    logic [1:0]  W_Exc;

    mem_access_stage_if dm();

    mem_access_stage #(.MAX_WAIT(TB_MAX_WAIT)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .M_Valid(M_Valid), .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
        .M_RegWrite(M_RegWrite), .M_MemtoReg(M_MemtoReg), .M_Branch(M_Branch),
        .M_Jump(M_Jump), .M_Zero(M_Zero), .M_Overflow(M_Overflow),
        .M_Btarg(M_Btarg), .M_Jtarg(M_Jtarg), .M_ALUout(M_ALUout), .M_busB(M_busB),
        .M_Rw(M_Rw), .dm(dm), .Mem_Stall(Mem_Stall), .PC_Sel(PC_Sel), .PC_Targ(PC_Targ),
        .W_Valid(W_Valid), .W_RegWrite(W_RegWrite), .W_Rw(W_Rw), .W_busW(W_busW),
        .W_Exc(W_Exc)
    );

    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    wexp_t       pend;
    logic [31:0] model_mem [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input wexp_t e);
        chk({tag, ".w_valid"},    32'(W_Valid),    32'(e.valid));
        chk({tag, ".w_regwrite"}, 32'(W_RegWrite), 32'(e.regwrite));
        chk({tag, ".w_exc"},      32'(W_Exc),      32'(e.exc));
        if (e.valid)    chk({tag, ".w_rw"},   32'(W_Rw), 32'(e.rw));
        if (e.regwrite) chk({tag, ".w_busw"}, W_busW,    e.busw);
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic drive_ins(input instr_t i);
        M_Valid = i.valid;  M_MemRead = i.rd;     M_MemWrite = i.wr;
        M_RegWrite = i.regwrite; M_MemtoReg = i.memtoreg;
        M_Branch = i.branch; M_Jump = i.jump;     M_Zero = i.zero; M_Overflow = i.ovf;
        M_Btarg = i.btarg;  M_Jtarg = i.jtarg;    M_ALUout = i.alu; M_busB = i.busb;
        M_Rw = i.rw;
    endtask

    // Present one instruction, holding it as long as the pipeline would; ack 'lat' cycles
    // after the request rises (negative or beyond the limit: never acknowledged).
    task automatic run_instr(input string tag, input instr_t ins, input int lat);
        logic        is_mem, mis, access, acked, exp_stall, exp_req;
        int          stall, n;
        logic [31:0] addr, ld, exp_targ;
        logic [1:0]  exp_sel;
        wexp_t       res;
        is_mem = ins.rd | ins.wr;
        mis    = (ins.alu[1:0] != 2'b00);
        access = ins.valid & is_mem & ~ins.ovf & ~mis;
        acked  = access && (lat >= 0) && (lat <= int'(TB_MAX_WAIT));
        stall  = !access ? 0 : (acked ? 2 + lat : 2 + int'(TB_MAX_WAIT));
        n      = access ? stall + 1 : 1;
        addr   = {ins.alu[31:2], 2'b00};
        ld     = mem_read(addr);
        res    = '0;
        if (ins.valid) begin
            res.valid = 1'b1;
            res.rw    = ins.rw;
            if (ins.ovf)                res.exc = 2'b01;
            else if (is_mem && mis)     res.exc = 2'b10;
            else if (access && !acked)  res.exc = 2'b11;
            res.regwrite = ins.regwrite & ~ins.wr & (res.exc == 2'b00);
            res.busw     = (access && ins.memtoreg) ? (acked ? ld : 32'h0) : ins.alu;
        end
        for (int c = 0; c < n; c++) begin
            drive_ins(ins);
            dm.Dm_Ack   = acked && (c == 1 + lat);
            dm.Dm_Rdata = dm.Dm_Ack ? ld : $urandom();
            @(posedge Clk);
            exp_stall = access && (c < stall);
            exp_req   = access && (c >= 1) && (c < stall);
            chk({tag, ".mem_stall"}, 32'(Mem_Stall), 32'(exp_stall));
            chk({tag, ".dm_req"},    32'(dm.Dm_Req), 32'(exp_req));
            if (exp_req) begin
                chk({tag, ".dm_we"},   32'(dm.Dm_We), 32'(ins.wr));
                chk({tag, ".dm_addr"}, dm.Dm_Addr,    addr);
                if (ins.wr) chk({tag, ".dm_wdata"}, dm.Dm_Wdata, ins.busb);
            end
            exp_sel  = 2'b00;
            exp_targ = 32'h0;
            if (ins.valid && !exp_stall) begin
                if (ins.jump) begin
                    exp_sel = 2'b10; exp_targ = ins.jtarg;
                end else if (ins.branch && ins.zero) begin
                    exp_sel = 2'b01; exp_targ = ins.btarg;
                end
            end
            chk({tag, ".pc_sel"},  32'(PC_Sel), 32'(exp_sel));
            chk({tag, ".pc_targ"}, PC_Targ,     exp_targ);
            if (c == 0)          chk_w({tag, ".prev"}, pend);
            else if (c < stall)  chk({tag, ".busy_w_valid"}, 32'(W_Valid), 32'h0);
            else                 chk_w({tag, ".done"}, res);
            @(negedge Clk); #1;
        end
        dm.Dm_Ack = 1'b0;
        if (acked && ins.wr) model_mem[addr] = ins.busb;
        pend = access ? '0 : res;
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        int     k;
        r       = '0;
        r.valid = ($urandom_range(0, 9) != 0);
        r.alu   = $urandom();
        r.busb  = $urandom();
        r.btarg = $urandom();
        r.jtarg = $urandom();
        r.rw    = 5'($urandom());
        r.zero  = 1'($urandom_range(0, 1));
        r.ovf   = ($urandom_range(0, 9) == 0);
        k       = $urandom_range(0, 4);
        case (k)
            0: r.regwrite = 1'b1;
            1, 2: begin
                r.alu = 32'h100 + 32'($urandom_range(0, 15) * 4);
                if ($urandom_range(0, 6) == 0) r.alu[1:0] = 2'($urandom_range(1, 3));
                if (k == 1) begin
                    r.rd = 1'b1; r.regwrite = 1'b1; r.memtoreg = 1'b1;
                end else begin
                    r.wr = 1'b1;
                end
            end
            3: r.branch = 1'b1;
            default: begin
                r.jump   = 1'b1;
                r.branch = 1'($urandom_range(0, 1));
            end
        endcase
        return r;
    endfunction

    initial begin
        instr_t ins;
        int     lat;
        pend  = '0;
        Rst_n = 1'b0;
        drive_ins('0);
        dm.Dm_Ack   = 1'b0;
        dm.Dm_Rdata = 32'h0;
        model_mem[32'h100] = 32'hDEAD_BEEF;
        repeat (2) @(negedge Clk);
        #1;
        @(posedge Clk);
        chk("reset.dm_req",    32'(dm.Dm_Req),  32'h0);
        chk("reset.dm_we",     32'(dm.Dm_We),   32'h0);
        chk("reset.dm_addr",   dm.Dm_Addr,      32'h0);
        chk("reset.dm_wdata",  dm.Dm_Wdata,     32'h0);
        chk("reset.mem_stall", 32'(Mem_Stall),  32'h0);
        chk_w("reset", '0);
        @(negedge Clk); #1;
        Rst_n = 1'b1;

        ins = '0; ins.valid = 1; ins.regwrite = 1; ins.alu = 32'h1234; ins.rw = 5'd5;
        run_instr("alu_1234", ins, 0);

        ins = '0; ins.valid = 1; ins.rd = 1; ins.regwrite = 1; ins.memtoreg = 1;
        ins.alu = 32'h100; ins.rw = 5'd7;
        run_instr("load_100", ins, 2);

        ins = '0; ins.valid = 1; ins.wr = 1; ins.alu = 32'h104; ins.busb = 32'hA5A5_A5A5;
        run_instr("store_104", ins, 1);

        ins = '0; ins.valid = 1; ins.rd = 1; ins.regwrite = 1; ins.memtoreg = 1;
        ins.alu = 32'h104; ins.rw = 5'd9;
        run_instr("load_104_back", ins, 0);

        ins = '0; ins.valid = 1; ins.rd = 1; ins.regwrite = 1; ins.memtoreg = 1;
        ins.alu = 32'h102; ins.rw = 5'd3;
        run_instr("load_misaligned", ins, 0);

        ins = '0; ins.valid = 1; ins.regwrite = 1; ins.ovf = 1; ins.alu = 32'h7FFF_FFFF; ins.rw = 5'd4;
        run_instr("add_overflow", ins, 0);

        ins = '0; ins.valid = 1; ins.rd = 1; ins.regwrite = 1; ins.memtoreg = 1; ins.ovf = 1;
        ins.alu = 32'h103; ins.rw = 5'd6;
        run_instr("ovf_over_misalign", ins, 0);

        ins = '0; ins.valid = 1; ins.rd = 1; ins.regwrite = 1; ins.memtoreg = 1;
        ins.alu = 32'h108; ins.rw = 5'd8;
        run_instr("load_timeout", ins, -1);

        run_instr("load_ack_last", ins, int'(TB_MAX_WAIT));

        ins = '0; ins.valid = 1; ins.branch = 1; ins.zero = 1; ins.jump = 1;
        ins.btarg = 32'h0000_4000; ins.jtarg = 32'h0000_8000;
        run_instr("jump_beats_branch", ins, 0);

        ins.jump = 0;
        run_instr("branch_taken", ins, 0);

        ins.valid = 0;
        run_instr("invalid_branch", ins, 0);

        // Reset while waiting on the bus, followed by a stray ack that must be ignored.
        ins = '0; ins.valid = 1; ins.rd = 1; ins.regwrite = 1; ins.memtoreg = 1;
        ins.alu = 32'h10C; ins.rw = 5'd2;
        drive_ins(ins);
        dm.Dm_Ack = 1'b0;
        @(posedge Clk); chk("rst_mid.idle_stall", 32'(Mem_Stall), 32'h1);
        @(negedge Clk); #1;
        @(posedge Clk); chk("rst_mid.req", 32'(dm.Dm_Req), 32'h1);
        @(negedge Clk); #1;
        Rst_n = 1'b0;
        @(posedge Clk); chk("rst_mid.wait_req", 32'(dm.Dm_Req), 32'h1);
        @(negedge Clk); #1;
        Rst_n = 1'b1;
        drive_ins('0);
        dm.Dm_Ack = 1'b1;
        @(posedge Clk);
        chk("rst_mid.req_dropped", 32'(dm.Dm_Req),  32'h0);
        chk("rst_mid.stall_clear", 32'(Mem_Stall),  32'h0);
        chk("rst_mid.w_valid",     32'(W_Valid),    32'h0);
        @(negedge Clk); #1;
        dm.Dm_Ack = 1'b0;
        pend = '0;

        for (int i = 0; i < 250; i++) begin
            lat = $urandom_range(0, 6);
            if (lat == 6) lat = -1;
            run_instr("rand", rand_instr(), lat);
        end

        run_instr("flush", '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
